lcd_seq: RTL and testbench



---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_nib_tx.sv | 79 +++++++
 rtl/lcd_seq.sv | 188 ++++++++++++++++++
 tb/tb_lcd_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state types and helpers for the LCD sequencer
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_4B_2L = 8'h28;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
    localparam logic [3:0] NIB_INIT_8B    = 4'h3;
    localparam logic [3:0] NIB_INIT_4B    = 4'h2;

    typedef enum logic [2:0] {
        PWRUP_WAIT, INIT_NIB, INIT_CMD, IDLE, SEND_HI, SEND_LO, WAIT
    } seq_state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD} tx_state_t;

    typedef enum logic [1:0] {PH_HI, PH_LO, PH_DLY} ph_t;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic logic [3:0] init_nib(input logic [1:0] i);
        return i == 2'd3 ? NIB_INIT_4B : NIB_INIT_8B;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? CMD_FUNC_4B_2L :
               i == 2'd1 ? CMD_DISP_ON :
               i == 2'd2 ? CMD_CLEAR : CMD_ENTRY_INC;
    endfunction

    // clear (0x01), home (0x02) and home-variant (0x03) need the long delay
    function automatic logic is_clear(input logic rs, input logic [7:0] d);
        return !rs && (d == CMD_CLEAR || d == CMD_HOME || d == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_nib_tx.sv
// lcd_nib_tx: drives one nibble onto the LCD pins with setup, enable pulse and hold
module lcd_nib_tx
    import lcd_pkg::*;
#(
    parameter int E_PULSE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nib,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       done
);

    localparam int PW = $clog2(E_PULSE) + 1;

    tx_state_t st_q, st_d;
    logic [PW-1:0] pc_q, pc_d;
    logic rs_q, rs_d, e_q, e_d;
    logic [3:0] d_q, d_d;

    // phase sequencing; a start in the hold cycle chains straight into the next setup
    always_comb begin
        st_d = st_q;
        pc_d = pc_q;
        rs_d = rs_q;
        e_d  = e_q;
        d_d  = d_q;
        case (st_q)
            TX_SETUP: begin
                st_d = TX_PULSE;
                e_d  = 1'b1;
                pc_d = PW'(E_PULSE - 1);
            end
            TX_PULSE: begin
                if (pc_q == '0) begin
                    st_d = TX_HOLD;
                    e_d  = 1'b0;
                end else begin
                    pc_d = pc_q - PW'(1);
                end
            end
            TX_HOLD: st_d = TX_IDLE;
            default: ;
        endcase
        if (start) begin
            st_d = TX_SETUP;
            rs_d = rs;
            d_d  = nib;
            e_d  = 1'b0;
        end
    end

    // pin and phase registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= TX_IDLE;
            pc_q <= '0;
            rs_q <= 1'b0;
            e_q  <= 1'b0;
            d_q  <= '0;
        end else begin
            st_q <= st_d;
            pc_q <= pc_d;
            rs_q <= rs_d;
            e_q  <= e_d;
            d_q  <= d_d;
        end
    end

    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_d  = d_q;
    assign done   = st_q == TX_HOLD;

endmodule

// File: rtl/lcd_seq.sv
// lcd_seq: power-up init and byte-write sequencer for a 4-bit HD44780-style LCD
module lcd_seq
    import lcd_pkg::*;
#(
    parameter int E_PULSE   = 4,
    parameter int T_POWERUP = 1000,
    parameter int T_INIT1   = 200,
    parameter int T_CMD     = 10,
    parameter int T_CLEAR   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);

    localparam int MAXP = max2(max2(max2(E_PULSE, T_POWERUP), max2(T_INIT1, T_CMD)), T_CLEAR);
    localparam int CW   = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] L_PWR   = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] L_INIT1 = CW'(T_INIT1 - 1);
    localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] L_CLR   = CW'(T_CLEAR - 1);

    seq_state_t state_q, state_d;
    ph_t ph_q, ph_d;
    logic [1:0] idx_q, idx_d, idx_nxt;
    logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
    logic rs_q, rs_d, ready_q, ready_d, done_q, done_d;
    logic [7:0] dat_q, dat_d, cmd_cur, cmd_nxt;
    logic tx_start, tx_rs, tx_done;
    logic [3:0] tx_nib;

    assign idx_nxt = idx_q + 2'd1;
    assign cmd_cur = init_cmd(idx_q);
    assign cmd_nxt = init_cmd(idx_nxt);
    assign cnt_dec = cnt_q - CW'(1);

    // next-state logic; each nibble start is issued one cycle early so setup lands on time
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        dat_d    = dat_q;
        ready_d  = 1'b0;
        done_d   = done_q;
        tx_start = 1'b0;
        tx_rs    = 1'b0;
        tx_nib   = 4'h0;
        case (state_q)
            PWRUP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = INIT_NIB;
                    ph_d     = PH_HI;
                    idx_d    = 2'd0;
                    tx_start = 1'b1;
                    tx_nib   = init_nib(2'd0);
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            INIT_NIB: begin
                if (ph_q != PH_DLY) begin
                    if (tx_done) begin
                        ph_d  = PH_DLY;
                        cnt_d = idx_q == 2'd0 ? L_INIT1 : L_CMD;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else begin
                    state_d  = idx_q == 2'd3 ? INIT_CMD : INIT_NIB;
                    idx_d    = idx_nxt;
                    ph_d     = PH_HI;
                    tx_start = 1'b1;
                    tx_nib   = idx_q == 2'd3 ? cmd_nxt[7:4] : init_nib(idx_nxt);
                end
            end
            INIT_CMD: begin
                if (ph_q == PH_HI) begin
                    if (tx_done) begin
                        ph_d     = PH_LO;
                        tx_start = 1'b1;
                        tx_nib   = cmd_cur[3:0];
                    end
                end else if (ph_q == PH_LO) begin
                    if (tx_done) begin
                        ph_d  = PH_DLY;
                        cnt_d = is_clear(1'b0, cmd_cur) ? L_CLR : L_CMD;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else if (idx_q == 2'd3) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    idx_d    = idx_nxt;
                    ph_d     = PH_HI;
                    tx_start = 1'b1;
                    tx_nib   = cmd_nxt[7:4];
                end
            end
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d  = SEND_HI;
                    rs_d     = req_rs;
                    dat_d    = req_data;
                    tx_start = 1'b1;
                    tx_rs    = req_rs;
                    tx_nib   = req_data[7:4];
                end else begin
                    ready_d = 1'b1;
                end
            end
            SEND_HI: begin
                if (tx_done) begin
                    state_d  = SEND_LO;
                    tx_start = 1'b1;
                    tx_rs    = rs_q;
                    tx_nib   = dat_q[3:0];
                end
            end
            SEND_LO: begin
                if (tx_done) begin
                    state_d = WAIT;
                    cnt_d   = is_clear(rs_q, dat_q) ? L_CLR : L_CMD;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // sequencer registers; reset restarts the full power-up wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PWRUP_WAIT;
            ph_q    <= PH_HI;
            idx_q   <= 2'd0;
            cnt_q   <= L_PWR;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    lcd_nib_tx #(.E_PULSE(E_PULSE)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .rs    (tx_rs),
        .nib   (tx_nib),
        .lcd_rs(lcd_rs),
        .lcd_e (lcd_e),
        .lcd_d (lcd_d),
        .done  (tx_done)
    );

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_seq.sv
// tb_lcd_seq: scoreboard bench for the LCD sequencer with default timing
module tb_lcd_seq;

    typedef struct packed {
        logic        rs;
        logic [3:0]  nib;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic req_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    exp_t sb[$];
    bit rw_bad = 1'b0;

    int   init_rise[12] = '{1001, 1207, 1223, 1239, 1255, 1261, 1277, 1283, 1299, 1305, 1411, 1417};
    logic [3:0] init_n[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

    lcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_data (req_data),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_d    (lcd_d)
    );

    always #5 clk = ~clk;

    // cycle index: 0 is the cycle in which reset is released
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // monitor: every enable pulse is matched against the scoreboard
    bit e_prev = 1'b0, stable = 1'b0;
    int width = 0;
    logic l_rs, p_rs;
    logic [3:0] l_d, p_d;
    exp_t x;

    always @(negedge clk) begin
        if (rst) begin
            e_prev = 1'b0;
        end else begin
            if (lcd_rw !== 1'b0) rw_bad = 1'b1;
            if (lcd_e && !e_prev) begin
                chk("pulse_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    chk("nib_rs", lcd_rs, x.rs);
                    chk("nib_d", lcd_d, x.nib);
                    chk("rise_cycle", cyc, x.cyc);
                end
                l_rs   = lcd_rs;
                l_d    = lcd_d;
                stable = (p_rs === lcd_rs) && (p_d === lcd_d);
                width  = 0;
            end
            if (lcd_e) begin
                width++;
                if (lcd_rs !== l_rs || lcd_d !== l_d) stable = 1'b0;
            end
            if (!lcd_e && e_prev) begin
                chk("e_width", width, 4);
                if (lcd_rs !== l_rs || lcd_d !== l_d) stable = 1'b0;
                chk("setup_hold_stable", stable, 1);
            end
            e_prev = lcd_e;
        end
        p_rs = lcd_rs;
        p_d  = lcd_d;
    end

    task automatic wait_init();
        int n;
        logic pd;
        for (int i = 0; i < 12; i++) sb.push_back('{1'b0, init_n[i], 32'(init_rise[i])});
        rst = 1'b0;
        n = 0;
        pd = 1'b0;
        while (!req_ready && n < 2000) begin
            pd = init_done;
            @(negedge clk);
            n++;
        end
        chk("init_ready_cycle", cyc, 1432);
        chk("init_done", init_done, 1);
        chk("done_before_ready", pd, 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] data, input int dly, input bit keep, output int k);
        int n;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hs_seen", req_ready, 1);
        k = cyc;
        sb.push_back('{rs, data[7:4], 32'(k + 2)});
        sb.push_back('{rs, data[3:0], 32'(k + 8)});
        @(negedge clk);
        req_valid = keep;
        chk("ready_drop", req_ready, 0);
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_return", cyc - k, dly);
    endtask

    initial begin
        int k1, k2;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", init_done, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_d", lcd_d, 0);
        wait_init();
        send(1'b1, 8'h41, 23, 1'b0, k1);
        send(1'b0, 8'h01, 113, 1'b0, k1);
        send(1'b0, 8'h80, 23, 1'b0, k1);
        send(1'b1, 8'h48, 23, 1'b1, k1);
        send(1'b1, 8'h49, 23, 1'b0, k2);
        chk("b2b_accept", k2, k1 + 23);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        chk("hs_ready_mid", req_ready, 1);
        k1 = cyc;
        sb.push_back('{1'b1, 4'h5, 32'(k1 + 2)});
        sb.push_back('{1'b1, 4'hA, 32'(k1 + 8)});
        repeat (9) @(negedge clk);
        chk("lo_pulse_active", lcd_e, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_lcd_e", lcd_e, 0);
        chk("async_lcd_d", lcd_d, 0);
        chk("async_lcd_rs", lcd_rs, 0);
        chk("async_ready", req_ready, 0);
        chk("async_done", init_done, 0);
        repeat (3) @(negedge clk);
        wait_init();
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("rw_low", rw_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
